// File: rtl/sr_debug_dump_pkg.sv
// Shared types and constants for the sr_cpu debug register dumper.
// DBG_ADDR_OV is here for the trace sink, which decodes the overflow word.
package sr_debug_dump_pkg;

  typedef enum logic [1:0] {DD_IDLE, DD_CAPTURE, DD_SEND, DD_DONE} dd_state_t;

  localparam logic [4:0] DBG_ADDR_PC = 5'd0;
  localparam logic [4:0] DBG_ADDR_OV = 5'd31;

  // Auto-dump counter width; one bit even when automatic dumps are disabled.
  function automatic int unsigned dd_cnt_width(input int unsigned period);
    return (period < 1) ? 1 : $clog2(period + 1);
  endfunction

endpackage

// File: rtl/sr_debug_dump.sv
// Walks the CPU debug register port and streams one captured word per register
// over valid/ready, optionally re-launching itself every AUTO_PERIOD idle cycles.
module sr_debug_dump
  import sr_debug_dump_pkg::*;
#(
  parameter int unsigned FIRST_REG   = 0,
  parameter int unsigned LAST_REG    = 31,
  parameter int unsigned AUTO_PERIOD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_addr,
  output logic        out_last
);

  localparam int unsigned CntW     = dd_cnt_width(AUTO_PERIOD);
  localparam logic [4:0]  FirstIdx = 5'(FIRST_REG);
  localparam logic [4:0]  LastIdx  = 5'(LAST_REG);

  dd_state_t       state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     out_data_q, out_data_d;
  logic [4:0]      out_addr_q, out_addr_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;

  logic is_last, handshake, auto_fire, launch;

  // idx is compared before incrementing, so LAST_REG=31 never wraps.
  assign is_last   = (idx_q == LastIdx);
  assign handshake = out_valid_q & out_ready;
  assign auto_fire = (AUTO_PERIOD > 0) && (state_q == DD_IDLE) &&
                     (32'(cnt_q) == AUTO_PERIOD - 1);
  assign launch    = (state_q == DD_IDLE) && (start || auto_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DD_IDLE:    if (launch) state_d = DD_CAPTURE;
      DD_CAPTURE: state_d = DD_SEND;
      DD_SEND:    if (handshake) state_d = is_last ? DD_DONE : DD_CAPTURE;
      DD_DONE:    state_d = DD_IDLE;
      default:    state_d = DD_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != DD_IDLE);
    done    = (state_q == DD_DONE);
    regAddr = (state_q == DD_CAPTURE) ? idx_q : DBG_ADDR_PC;
  end

  always_comb begin
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (launch) begin
      cnt_d = '0;
    end else if ((state_q == DD_IDLE) && (AUTO_PERIOD > 0)) begin
      cnt_d = cnt_q + CntW'(1);
    end

    unique case (state_q)
      DD_CAPTURE: begin
        out_data_d  = regData;
        out_addr_d  = idx_q;
        out_valid_d = 1'b1;
        out_last_d  = is_last;
      end
      DD_SEND: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          if (!is_last) idx_d = idx_q + 5'd1;
        end
      end
      DD_DONE: idx_d = FirstIdx;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= FirstIdx;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_sr_debug_dump.sv
// Scoreboard bench for sr_debug_dump: default, single-register and auto-trigger instances
// share one clock and reset; a small CPU model answers the debug port.
module tb_sr_debug_dump;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  word_t sb[$];

  logic [31:0] pc_val = 32'h0000_1234;
  logic        ov_flag = 1'b1;

  function automatic logic [31:0] cpu_reg(input logic [4:0] a, input logic [31:0] pc,
                                          input logic ov);
    if (a == 5'd0) return pc;
    if (a == 5'd31) return {31'b0, ov};
    return 32'hC0DE_0000 | {19'b0, a, 8'h00} | {27'b0, a};
  endfunction

  // Default instance
  logic start = 1'b0, busy, done, out_valid, out_ready = 1'b1, out_last;
  logic [4:0] reg_addr, out_addr;
  logic [31:0] reg_data, out_data;
  assign reg_data = cpu_reg(reg_addr, pc_val, ov_flag);

  sr_debug_dump u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .regAddr(reg_addr), .regData(reg_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
  );

  // Single-register instance
  logic o_start = 1'b0, o_busy, o_done, o_out_valid, o_out_ready = 1'b1, o_out_last;
  logic [4:0] o_reg_addr, o_out_addr;
  logic [31:0] o_reg_data, o_out_data;
  assign o_reg_data = cpu_reg(o_reg_addr, pc_val, ov_flag);

  sr_debug_dump #(.FIRST_REG(5), .LAST_REG(5), .AUTO_PERIOD(0)) u_one (
    .clk(clk), .rst(rst), .start(o_start), .busy(o_busy), .done(o_done),
    .regAddr(o_reg_addr), .regData(o_reg_data), .out_valid(o_out_valid),
    .out_ready(o_out_ready), .out_data(o_out_data), .out_addr(o_out_addr),
    .out_last(o_out_last)
  );

  // Auto-trigger instance
  logic a_start = 1'b0, a_busy, a_done, a_out_valid, a_out_ready = 1'b1, a_out_last;
  logic [4:0] a_reg_addr, a_out_addr;
  logic [31:0] a_reg_data, a_out_data;
  assign a_reg_data = cpu_reg(a_reg_addr, pc_val, ov_flag);

  sr_debug_dump #(.FIRST_REG(0), .LAST_REG(3), .AUTO_PERIOD(8)) u_auto (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .regAddr(a_reg_addr), .regData(a_reg_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_addr(a_out_addr),
    .out_last(a_out_last)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if ({busy, done, out_valid, out_last} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, out_valid, out_last});
    end
    vectors++;
    if (out_data !== 32'h0 || out_addr !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h/%0d expected 0/0", out_data, out_addr);
    end
    vectors++;
    if (reg_addr !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_regaddr: got %0d expected 0", reg_addr);
    end
    rst = 1'b0;
    step();
    vectors++;
    if ({busy, done, out_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b expected 000", {busy, done, out_valid});
    end
  endtask

  task automatic run_main_dump(input string tag, input int stall_addr, input int stall_len,
                               input bit poke);
    int t0, first_valid, done_cyc, n_words, stall_left, lim;
    word_t got, held, exp_w;
    sb.delete();
    for (int a = 0; a < 32; a++) begin
      exp_w.data = cpu_reg(5'(a), pc_val, ov_flag);
      exp_w.addr = 5'(a);
      exp_w.last = (a == 31);
      sb.push_back(exp_w);
    end
    first_valid = -1;
    done_cyc = -1;
    n_words = 0;
    stall_left = -1;
    held = '0;
    start = 1'b1;
    t0 = cyc;
    step();
    start = 1'b0;
    lim = 0;
    while (done_cyc < 0 && lim < 300) begin
      lim++;
      out_ready = 1'b1;
      start = poke && busy && ((cyc - t0) % 7 == 3);
      got = '{data: out_data, addr: out_addr, last: out_last};
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (stall_len > 0 && out_valid && int'(out_addr) == stall_addr) begin
        if (stall_left < 0) begin
          stall_left = stall_len;
          held = got;
        end else begin
          vectors++;
          if (got !== held) begin
            miscompares++;
            $display("FAIL %s_stall_hold: got %h/%0d/%b expected %h/%0d/%b", tag,
                     got.data, got.addr, got.last, held.data, held.addr, held.last);
          end
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end
      end
      if (out_valid && out_ready) begin
        n_words++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL %s_extra_word: got addr %0d expected no word", tag, got.addr);
        end else begin
          exp_w = sb.pop_front();
          if (got !== exp_w) begin
            miscompares++;
            $display("FAIL %s_word: got %h/%0d/%b expected %h/%0d/%b", tag, got.data,
                     got.addr, got.last, exp_w.data, exp_w.addr, exp_w.last);
          end
        end
      end
      if (done) done_cyc = cyc;
      step();
    end
    start = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (done_cyc < 0) begin
      miscompares++;
      $display("FAIL %s_timeout: got no done expected done", tag);
    end
    vectors++;
    if (first_valid != t0 + 2) begin
      miscompares++;
      $display("FAIL %s_first_valid: got %0d expected %0d", tag, first_valid - t0, 2);
    end
    vectors++;
    if (done_cyc - t0 != 65 + stall_len) begin
      miscompares++;
      $display("FAIL %s_done_cycle: got %0d expected %0d", tag, done_cyc - t0,
               65 + stall_len);
    end
    vectors++;
    if (n_words != 32 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_word_count: got %0d (left %0d) expected 32 (left 0)", tag, n_words,
               sb.size());
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({busy, done, out_valid} !== 3'b000) begin
        miscompares++;
        $display("FAIL %s_after_done: got %b expected 000", tag, {busy, done, out_valid});
      end
      step();
    end
  endtask

  task automatic test_full_dump();
    pc_val = 32'h0000_1234;
    ov_flag = 1'b1;
    run_main_dump("full", -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    pc_val = 32'h8000_0F00;
    ov_flag = 1'b0;
    run_main_dump("bp", 3, 5, 1'b0);
  endtask

  task automatic test_start_while_busy();
    pc_val = 32'h0BAD_CAFE;
    ov_flag = 1'b1;
    run_main_dump("busy_start", -1, 0, 1'b1);
  endtask

  task automatic test_single_word();
    int n_busy, n_done, n_words;
    word_t got, exp_w;
    n_busy = 0;
    n_done = 0;
    n_words = 0;
    exp_w = '{data: cpu_reg(5'd5, pc_val, ov_flag), addr: 5'd5, last: 1'b1};
    sb.delete();
    sb.push_back(exp_w);
    o_start = 1'b1;
    step();
    o_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (o_busy) n_busy++;
      if (o_done) n_done++;
      if (o_out_valid && o_out_ready) begin
        n_words++;
        got = '{data: o_out_data, addr: o_out_addr, last: o_out_last};
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL single_extra_word: got addr %0d expected no word", got.addr);
        end else begin
          exp_w = sb.pop_front();
          if (got !== exp_w) begin
            miscompares++;
            $display("FAIL single_word: got %h/%0d/%b expected %h/%0d/%b", got.data,
                     got.addr, got.last, exp_w.data, exp_w.addr, exp_w.last);
          end
        end
      end
      step();
    end
    vectors++;
    if (n_busy != 3) begin
      miscompares++;
      $display("FAIL single_busy_cycles: got %0d expected 3", n_busy);
    end
    vectors++;
    if (n_done != 1 || n_words != 1) begin
      miscompares++;
      $display("FAIL single_counts: got done %0d words %0d expected 1 1", n_done, n_words);
    end
  endtask

  task automatic test_reset_mid();
    int lim;
    sb.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    lim = 0;
    while (!(out_valid && out_addr == 5'd12) && lim < 100) begin
      step();
      lim++;
    end
    out_ready = 1'b0;
    vectors++;
    if (!(out_valid && out_addr == 5'd12)) begin
      miscompares++;
      $display("FAIL rst_mid_reach: got addr %0d expected valid addr 12", out_addr);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({out_valid, busy, done} !== 3'b000 || reg_addr !== 5'd0) begin
      miscompares++;
      $display("FAIL rst_mid_clear: got %b/%0d expected 000/0", {out_valid, busy, done},
               reg_addr);
    end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    run_main_dump("after_rst", -1, 0, 1'b0);
  endtask

  task automatic auto_frame(input string tag, input bit coincide);
    int gap, nw, nd, lim;
    word_t got, exp_w;
    gap = 0;
    nw = 0;
    nd = 0;
    step();
    while (!a_busy && gap < 50) begin
      gap++;
      if (coincide && gap == 8) a_start = 1'b1;
      step();
      a_start = 1'b0;
    end
    lim = 0;
    while (nd == 0 && lim < 40) begin
      lim++;
      if (a_out_valid && a_out_ready) begin
        got = '{data: a_out_data, addr: a_out_addr, last: a_out_last};
        exp_w = '{data: cpu_reg(5'(nw), pc_val, ov_flag), addr: 5'(nw), last: (nw == 3)};
        vectors++;
        if (got !== exp_w) begin
          miscompares++;
          $display("FAIL %s_word: got %h/%0d/%b expected %h/%0d/%b", tag, got.data,
                   got.addr, got.last, exp_w.data, exp_w.addr, exp_w.last);
        end
        nw++;
      end
      if (a_done) nd++;
      else step();
    end
    vectors++;
    if (gap != 8) begin
      miscompares++;
      $display("FAIL %s_idle_gap: got %0d expected 8", tag, gap);
    end
    vectors++;
    if (nw != 4 || nd != 1) begin
      miscompares++;
      $display("FAIL %s_counts: got words %0d done %0d expected 4 1", tag, nw, nd);
    end
  endtask

  task automatic test_auto();
    int lim;
    lim = 0;
    while (!a_done && lim < 100) begin
      step();
      lim++;
    end
    vectors++;
    if (!a_done) begin
      miscompares++;
      $display("FAIL auto_sync: got no done expected an automatic dump");
      return;
    end
    auto_frame("auto", 1'b0);
    auto_frame("auto_coincide", 1'b1);
    auto_frame("auto_after", 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_start_while_busy();
    test_single_word();
    test_reset_mid();
    test_auto();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
